// File: rtl/loadable_watch_hms_pkg.sv
// Shared constants for the hh:mm:ss loadable watch: field indices, button bit
// positions, BCD digit width, the mode enum and a small binary-to-BCD helper.
package loadable_watch_hms_pkg;

   localparam int BCD_W = 4;

   localparam logic [1:0] FLD_SEC  = 2'd0;
   localparam logic [1:0] FLD_MIN  = 2'd1;
   localparam logic [1:0] FLD_HOUR = 2'd2;

   localparam int BTN_MODE = 0;
   localparam int BTN_SEL  = 1;
   localparam int BTN_INC  = 2;
   localparam int BTN_DEC  = 3;

   typedef enum logic {
      MODE_RUN = 1'b0,
      MODE_SET = 1'b1
   } mode_t;

   // Two-digit BCD of a binary value 0..99 (used for field maxima)
   function automatic logic [2*BCD_W-1:0] to_bcd2(input int unsigned bin);
      to_bcd2 = {BCD_W'(bin / 10), BCD_W'(bin % 10)};
   endfunction

endpackage

// File: rtl/loadable_watch_hms_bcd_updown_counter.sv
// Two-digit BCD counter with synchronous load, increment and decrement.
// The count wraps within 00..MOD-1; carry_out flags an increment that wraps.
module bcd_updown_counter
   import loadable_watch_hms_pkg::*;
#(
   parameter int MOD = 60
)
(
   input  logic               clk,
   input  logic               reset_p,
   input  logic               load,
   input  logic [2*BCD_W-1:0] load_val,
   input  logic               inc,
   input  logic               dec,
   output logic [2*BCD_W-1:0] value,
   output logic               carry_out
);

   localparam logic [2*BCD_W-1:0] MAX_VAL = to_bcd2(MOD - 1);

   logic [BCD_W-1:0] tens;
   logic [BCD_W-1:0] ones;
   logic             step_up;
   logic             step_dn;

   assign tens      = value[2*BCD_W-1:BCD_W];
   assign ones      = value[BCD_W-1:0];
   assign step_up   = inc & ~dec & ~load;
   assign step_dn   = dec & ~inc & ~load;
   assign carry_out = step_up & (value == MAX_VAL);

   // Load has priority; simultaneous inc and dec cancel out
   always_ff @(posedge clk) begin
      if (reset_p) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (step_up) begin
         if (value == MAX_VAL)
            value <= '0;
         else if (ones == 4'd9)
            value <= {tens + 4'd1, 4'd0};
         else
            value <= {tens, ones + 4'd1};
      end else if (step_dn) begin
         if (value == '0)
            value <= MAX_VAL;
         else if (ones == 4'd0)
            value <= {tens - 4'd1, 4'd9};
         else
            value <= {tens, ones - 4'd1};
      end
   end

endmodule

// File: rtl/loadable_watch_hms.sv
// Free-running hh:mm:ss BCD watch with its own prescaler and a set mode that
// edits a shadow copy field by field; leaving set mode loads the shadow.
module loadable_watch_hms
   import loadable_watch_hms_pkg::*;
#(
   parameter int TICK_DIV = 100_000_000,
   parameter int HOUR_MOD = 24
)
(
   input  logic        clk,
   input  logic        reset_p,
   input  logic [3:0]  btn_pedge,
   output logic [23:0] value,
   output logic        set_mode,
   output logic [1:0]  field_sel,
   output logic        blink,
   output logic        sec_tick
);

   localparam int PRE_W = $clog2(TICK_DIV);
   localparam int HALF  = TICK_DIV / 2;
   localparam int BLK_W = (HALF > 1) ? $clog2(HALF) : 1;

   mode_t            mode;
   logic [PRE_W-1:0] prescale;
   logic [BLK_W-1:0] blink_cnt;

   logic toggle;
   logic enter_set;
   logic exit_set;
   logic edit_ok;
   logic run_tick;
   logic sec_carry;
   logic min_carry;
   logic [3:0] unused_carries;

   logic [2*BCD_W-1:0] run_sec, run_min, run_hour;
   logic [2*BCD_W-1:0] sh_sec, sh_min, sh_hour;

   assign toggle    = btn_pedge[BTN_MODE];
   assign enter_set = toggle & (mode == MODE_RUN);
   assign exit_set  = toggle & (mode == MODE_SET);
   assign edit_ok   = (mode == MODE_SET) & ~toggle;
   assign run_tick  = sec_tick & ~exit_set;
   assign set_mode  = (mode == MODE_SET);
   assign value     = set_mode ? {sh_hour, sh_min, sh_sec} : {run_hour, run_min, run_sec};

   // Prescaler: sec_tick is high while the count sits at TICK_DIV-1; an exit restarts the second
   always_ff @(posedge clk) begin
      if (reset_p || exit_set) begin
         prescale <= '0;
         sec_tick <= 1'b0;
      end else begin
         if (prescale == PRE_W'(TICK_DIV - 1))
            prescale <= '0;
         else
            prescale <= prescale + PRE_W'(1);
         sec_tick <= (prescale == PRE_W'(TICK_DIV - 2));
      end
   end

   // Mode/field FSM with the blink phase counter that only runs while editing
   always_ff @(posedge clk) begin
      if (reset_p) begin
         mode      <= MODE_RUN;
         field_sel <= FLD_SEC;
         blink     <= 1'b0;
         blink_cnt <= '0;
      end else if (enter_set) begin
         mode      <= MODE_SET;
         field_sel <= FLD_SEC;
         blink     <= 1'b1;
         blink_cnt <= '0;
      end else if (exit_set) begin
         mode      <= MODE_RUN;
         blink     <= 1'b0;
         blink_cnt <= '0;
      end else if (mode == MODE_SET) begin
         if (btn_pedge[BTN_SEL])
            field_sel <= (field_sel == FLD_HOUR) ? FLD_SEC : field_sel + 2'd1;
         if (blink_cnt == BLK_W'(HALF - 1)) begin
            blink_cnt <= '0;
            blink     <= ~blink;
         end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
         end
      end
   end

   bcd_updown_counter #(.MOD(60)) u_run_sec (
      .clk(clk), .reset_p(reset_p), .load(exit_set), .load_val(sh_sec),
      .inc(run_tick), .dec(1'b0), .value(run_sec), .carry_out(sec_carry)
   );

   bcd_updown_counter #(.MOD(60)) u_run_min (
      .clk(clk), .reset_p(reset_p), .load(exit_set), .load_val(sh_min),
      .inc(sec_carry), .dec(1'b0), .value(run_min), .carry_out(min_carry)
   );

   bcd_updown_counter #(.MOD(HOUR_MOD)) u_run_hour (
      .clk(clk), .reset_p(reset_p), .load(exit_set), .load_val(sh_hour),
      .inc(min_carry), .dec(1'b0), .value(run_hour), .carry_out(unused_carries[3])
   );

   bcd_updown_counter #(.MOD(60)) u_sh_sec (
      .clk(clk), .reset_p(reset_p), .load(enter_set), .load_val(run_sec),
      .inc(edit_ok & btn_pedge[BTN_INC] & (field_sel == FLD_SEC)),
      .dec(edit_ok & btn_pedge[BTN_DEC] & (field_sel == FLD_SEC)),
      .value(sh_sec), .carry_out(unused_carries[0])
   );

   bcd_updown_counter #(.MOD(60)) u_sh_min (
      .clk(clk), .reset_p(reset_p), .load(enter_set), .load_val(run_min),
      .inc(edit_ok & btn_pedge[BTN_INC] & (field_sel == FLD_MIN)),
      .dec(edit_ok & btn_pedge[BTN_DEC] & (field_sel == FLD_MIN)),
      .value(sh_min), .carry_out(unused_carries[1])
   );

   bcd_updown_counter #(.MOD(HOUR_MOD)) u_sh_hour (
      .clk(clk), .reset_p(reset_p), .load(enter_set), .load_val(run_hour),
      .inc(edit_ok & btn_pedge[BTN_INC] & (field_sel == FLD_HOUR)),
      .dec(edit_ok & btn_pedge[BTN_DEC] & (field_sel == FLD_HOUR)),
      .value(sh_hour), .carry_out(unused_carries[2])
   );

endmodule

// File: tb/tb_loadable_watch_hms.sv
// Bench for loadable_watch_hms: two instances (HOUR_MOD 24 and 12) driven one
// at a time and compared every cycle against a seconds-based reference model.
module tb_loadable_watch_hms;

   localparam int TD = 10;

   logic        clk = 1'b0;
   logic        resetA, resetB;
   logic [3:0]  btnA, btnB;
   logic [23:0] valueA, valueB;
   logic        setA, setB, blinkA, blinkB, tickA, tickB;
   logic [1:0]  fieldA, fieldB;

   bit          useB = 1'b0;
   logic [23:0] obsValue;
   logic        obsSet, obsBlink, obsTick;
   logic [1:0]  obsField;

   int testsRun = 0;
   int testsFailed = 0;

   // Reference model state: running time as total seconds, shadow as fields
   int hourMod = 24;
   int runSecs, shH, shM, shS, mField, preCnt, blinkCnt;
   bit mMode;

   always #5 clk = ~clk;

   assign obsValue = useB ? valueB : valueA;
   assign obsSet   = useB ? setB   : setA;
   assign obsField = useB ? fieldB : fieldA;
   assign obsBlink = useB ? blinkB : blinkA;
   assign obsTick  = useB ? tickB  : tickA;

   loadable_watch_hms #(.TICK_DIV(TD), .HOUR_MOD(24)) dutA (
      .clk(clk), .reset_p(resetA), .btn_pedge(btnA), .value(valueA),
      .set_mode(setA), .field_sel(fieldA), .blink(blinkA), .sec_tick(tickA)
   );

   loadable_watch_hms #(.TICK_DIV(TD), .HOUR_MOD(12)) dutB (
      .clk(clk), .reset_p(resetB), .btn_pedge(btnB), .value(valueB),
      .set_mode(setB), .field_sel(fieldB), .blink(blinkB), .sec_tick(tickB)
   );

   function automatic logic [23:0] toBcd(input int h, input int m, input int s);
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [23:0] expValue();
      if (mMode)
         return toBcd(shH, shM, shS);
      return toBcd(runSecs / 3600, (runSecs / 60) % 60, runSecs % 60);
   endfunction

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkEq({tag, " value"}, 32'(obsValue), 32'(expValue()));
      checkEq({tag, " set_mode"}, 32'(obsSet), 32'(mMode));
      checkEq({tag, " field_sel"}, 32'(obsField), 32'(mField));
      checkEq({tag, " blink"}, 32'(obsBlink), 32'(mMode && ((blinkCnt / (TD / 2)) % 2 == 0)));
      checkEq({tag, " sec_tick"}, 32'(obsTick), 32'(preCnt == TD - 1));
   endtask

   // One clock of the watch described in plain arithmetic on seconds
   task automatic modelStep(input logic [3:0] b, input logic r);
      bit tick;
      int delta;
      if (r) begin
         runSecs = 0; shH = 0; shM = 0; shS = 0;
         mMode = 0; mField = 0; preCnt = 0; blinkCnt = 0;
         return;
      end
      tick = (preCnt == TD - 1);
      if (b[0] && !mMode) begin
         shH = runSecs / 3600; shM = (runSecs / 60) % 60; shS = runSecs % 60;
         mMode = 1; mField = 0; blinkCnt = 0;
         if (tick) runSecs = (runSecs + 1) % (hourMod * 3600);
         preCnt = (preCnt + 1) % TD;
      end else if (b[0]) begin
         runSecs = shH * 3600 + shM * 60 + shS;
         mMode = 0;
         preCnt = 0;
      end else begin
         if (tick) runSecs = (runSecs + 1) % (hourMod * 3600);
         preCnt = (preCnt + 1) % TD;
         if (mMode) begin
            blinkCnt++;
            if (b[2] != b[3]) begin
               delta = b[2] ? 1 : -1;
               case (mField)
                  0: shS = (shS + delta + 60) % 60;
                  1: shM = (shM + delta + 60) % 60;
                  default: shH = (shH + delta + hourMod) % hourMod;
               endcase
            end
            if (b[1]) mField = (mField + 1) % 3;
         end
      end
   endtask

   task automatic applyStimulus(input logic [3:0] b, input logic r);
      if (useB) begin
         btnB = b; resetB = r;
      end else begin
         btnA = b; resetA = r;
      end
      @(posedge clk);
      modelStep(b, r);
      #1;
      btnA = '0; btnB = '0; resetA = 1'b0; resetB = 1'b0;
      checkOutput("step");
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(4'b0000, 1'b0);
   endtask

   // Walk the shadow to a target time from field sec, using the model's shadow
   task automatic setShadowTo(input int h, input int m, input int s);
      int n;
      n = (s - shS + 60) % 60;
      for (int k = 0; k < n; k++) applyStimulus(4'b0100, 1'b0);
      applyStimulus(4'b0010, 1'b0);
      n = (m - shM + 60) % 60;
      for (int k = 0; k < n; k++) applyStimulus(4'b0100, 1'b0);
      applyStimulus(4'b0010, 1'b0);
      n = (h - shH + hourMod) % hourMod;
      for (int k = 0; k < n; k++) applyStimulus(4'b0100, 1'b0);
   endtask

   task automatic randomRun(input int n);
      logic [3:0] b;
      for (int k = 0; k < n; k++) begin
         b = '0;
         b[0] = ($urandom_range(0, 19) == 0);
         b[1] = ($urandom_range(0, 3) == 0);
         b[2] = ($urandom_range(0, 2) == 0);
         b[3] = ($urandom_range(0, 2) == 0);
         applyStimulus(b, 1'b0);
      end
   endtask

   initial begin
      int tickCount;
      int lastTick;
      int spacingBad;
      int guard;
      logic [23:0] expShadow;

      resetA = 1'b1; resetB = 1'b1; btnA = '0; btnB = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      applyStimulus(4'b0000, 1'b1);
      checkEq("reset value", 32'(obsValue), 32'h0);
      checkEq("reset set_mode", 32'(obsSet), 32'h0);
      checkEq("reset field_sel", 32'(obsField), 32'h0);
      checkEq("reset blink", 32'(obsBlink), 32'h0);
      checkEq("reset sec_tick", 32'(obsTick), 32'h0);

      // 600 free-running cycles: one minute, 60 ticks evenly spaced
      tickCount = 0; lastTick = -1; spacingBad = 0;
      for (int i = 1; i <= 600; i++) begin
         applyStimulus(4'b0000, 1'b0);
         if (obsTick) begin
            if (lastTick >= 0 && (i - lastTick) != TD) spacingBad++;
            tickCount++;
            lastTick = i;
         end
      end
      checkEq("one minute value", 32'(obsValue), 32'h000100);
      checkEq("tick count", 32'(tickCount), 32'd60);
      checkEq("tick spacing", 32'(spacingBad), 32'd0);
      checkEq("last tick cycle", 32'(lastTick), 32'd599);

      // Preload 23:59:58 and roll over midnight
      applyStimulus(4'b0001, 1'b0);
      checkEq("enter set", 32'(obsSet), 32'h1);
      setShadowTo(23, 59, 58);
      applyStimulus(4'b0001, 1'b0);
      checkEq("preload value", 32'(obsValue), 32'h235958);
      idle(19);
      checkEq("before midnight", 32'(obsValue), 32'h235959);
      applyStimulus(4'b0000, 1'b0);
      checkEq("midnight carry", 32'(obsValue), 32'h000000);

      // Enter at 00:00:05, dec sec past zero, hour inc wraps 25 -> 01
      idle(50);
      checkEq("five seconds", 32'(obsValue), 32'h000005);
      applyStimulus(4'b0001, 1'b0);
      checkEq("shadow captured", 32'(obsValue), 32'h000005);
      for (int k = 0; k < 6; k++) applyStimulus(4'b1000, 1'b0);
      checkEq("sec dec wrap", 32'(obsValue), 32'h000059);
      applyStimulus(4'b0010, 1'b0);
      applyStimulus(4'b0010, 1'b0);
      checkEq("field hour", 32'(obsField), 32'd2);
      for (int k = 0; k < 25; k++) applyStimulus(4'b0100, 1'b0);
      checkEq("hour inc wrap", 32'(obsValue), 32'h010059);
      applyStimulus(4'b0001, 1'b0);
      checkEq("exit load", 32'(obsValue), 32'h010059);
      checkEq("exit mode", 32'(obsSet), 32'h0);
      idle(9);
      checkEq("no early tick", 32'(obsValue), 32'h010059);
      checkEq("first tick after exit", 32'(obsTick), 32'h1);
      applyStimulus(4'b0000, 1'b0);
      checkEq("tick applied", 32'(obsValue), 32'h010100);

      // Button combinations
      applyStimulus(4'b0101, 1'b0);
      checkEq("mode+inc enter", 32'(obsValue), 32'h010100);
      checkEq("mode+inc set", 32'(obsSet), 32'h1);
      applyStimulus(4'b1100, 1'b0);
      checkEq("inc+dec none", 32'(obsValue), 32'h010100);
      applyStimulus(4'b0110, 1'b0);
      checkEq("sel+inc old field", 32'(obsValue), 32'h010101);
      checkEq("sel+inc field", 32'(obsField), 32'd1);
      applyStimulus(4'b0101, 1'b0);
      checkEq("mode+inc exit", 32'(obsValue), 32'h010101);

      // Exit coincident with sec_tick: load wins
      applyStimulus(4'b0001, 1'b0);
      for (int k = 0; k < 3; k++) applyStimulus(4'b0100, 1'b0);
      guard = 0;
      while (preCnt != TD - 1 && guard < 2 * TD) begin
         applyStimulus(4'b0000, 1'b0);
         guard++;
      end
      checkEq("tick alignment reached", 32'(guard < 2 * TD), 32'h1);
      checkEq("tick before exit", 32'(obsTick), 32'h1);
      expShadow = toBcd(shH, shM, shS);
      applyStimulus(4'b0001, 1'b0);
      checkEq("coincident exit", 32'(obsValue), 32'(expShadow));

      // Randomized buttons against the model
      randomRun(400);

      // HOUR_MOD = 12 instance
      useB = 1'b1;
      hourMod = 12;
      applyStimulus(4'b0000, 1'b1);
      checkEq("B reset value", 32'(obsValue), 32'h0);
      applyStimulus(4'b0001, 1'b0);
      setShadowTo(11, 59, 58);
      applyStimulus(4'b0001, 1'b0);
      checkEq("B preload", 32'(obsValue), 32'h115958);
      idle(19);
      checkEq("B 11:59:59", 32'(obsValue), 32'h115959);
      applyStimulus(4'b0000, 1'b0);
      checkEq("B hour wrap", 32'(obsValue), 32'h000000);
      randomRun(200);

      // Reset in the middle of an edit
      if (!mMode) applyStimulus(4'b0001, 1'b0);
      applyStimulus(4'b0100, 1'b0);
      checkEq("B editing", 32'(obsSet), 32'h1);
      applyStimulus(4'b0100, 1'b1);
      checkEq("mid-edit reset value", 32'(obsValue), 32'h0);
      checkEq("mid-edit reset set_mode", 32'(obsSet), 32'h0);
      checkEq("mid-edit reset field_sel", 32'(obsField), 32'h0);
      checkEq("mid-edit reset blink", 32'(obsBlink), 32'h0);
      checkEq("mid-edit reset sec_tick", 32'(obsTick), 32'h0);
      idle(15);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
